sata_oob_controller: RTL and testbench
======================================

Name: sata_oob_controller

Overview:
Host-side SATA out-of-band (OOB) sequencer. It drives COMRESET/COMWAKE requests to the transceiver platform and detects the device's COMINIT/COMWAKE responses. It then performs the D10.2/ALIGN speed-negotiation handshake and asserts linkup once the link carries non-ALIGN primitives. It sits inside the SATA PHY layer, between the transceiver wrapper and the link-maintenance logic, and owns tx data only while linkup is low.

Parameters:
TIMEOUT_CYCLES, 66000, cycles to wait for a device response before retrying COMRESET (880 us at 75 MHz).
SYNC_COUNT, 3, consecutive valid non-ALIGN dwords required after ALIGN to declare linkup.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  reset, asynchronous, active-low.
phy_error  in  1  transceiver decode/disparity error.
platform_ready  in  1  transceiver PLLs/resets done.
platform_error  out  1  sticky: platform_ready dropped while sequencing.
linkup  out  1  OOB complete, link established.
tx_dout  out  32  transmit dword.
tx_is_k  out  1  byte 0 of tx_dout is a K character.
tx_comm_reset  out  1  request COMRESET burst.
tx_comm_wake  out  1  request COMWAKE burst.
tx_set_elec_idle  out  1  hold transmitter in electrical idle.
tx_oob_complete  in  1  platform finished the requested OOB burst.
rx_din  in  32  received dword.
rx_is_k  in  4  per-byte K flags of rx_din.
comm_init_detect  in  1  COMINIT detected from device.
comm_wake_detect  in  1  COMWAKE detected from device.
rx_is_elec_idle  in  1  receiver sees electrical idle.
rx_byte_is_aligned  in  1  comma alignment achieved.
lax_state  out  4  current state encoding, for debug/logic analyser.

Behaviour:
- Reset (rst=0, async): state IDLE, timer 0, sync counter 0. Outputs: linkup=0, tx_dout=0, tx_is_k=0, tx_comm_reset=0, tx_comm_wake=0, tx_set_elec_idle=1, platform_error=0, lax_state=0.
- All outputs are registered; lax_state equals the state code.
- State codes and transitions:
  - 0 IDLE: elec idle. Goes to SEND_RESET when platform_ready=1.
  - 1 SEND_RESET: tx_comm_reset=1 until tx_oob_complete=1, then WAIT_INIT with the timer cleared.
  - 2 WAIT_INIT: comm_init_detect=1 goes to WAIT_INIT_END. Timer reaching TIMEOUT_CYCLES-1 goes to SEND_RESET.
  - 3 WAIT_INIT_END: goes to SEND_WAKE when comm_init_detect=0.
  - 4 SEND_WAKE: tx_comm_wake=1 until tx_oob_complete=1, then WAIT_WAKE with the timer cleared.
  - 5 WAIT_WAKE: comm_wake_detect=1 goes to WAIT_WAKE_END. Timeout goes to SEND_RESET.
  - 6 WAIT_WAKE_END: goes to SEND_D10_2 when comm_wake_detect=0, timer cleared.
  - 7 SEND_D10_2: tx_set_elec_idle=0, tx_dout=32'h4A4A4A4A, tx_is_k=0. An ALIGN is detected when rx_din==32'h7B4A4ABC, rx_is_k[0]=1 and rx_byte_is_aligned=1; detection goes to SEND_ALIGN. Timeout goes to SEND_RESET.
  - 8 SEND_ALIGN: tx_dout=32'h7B4A4ABC, tx_is_k=1. A dword with rx_is_k[0]=1, rx_din != ALIGN and phy_error=0 increments the sync counter; any other dword clears it. The counter reaching SYNC_COUNT goes to READY.
  - 9 READY: linkup=1, tx_dout holds ALIGN. phy_error=1 or rx_is_elec_idle=1 drops linkup and goes to IDLE.
- The timer is 20 bits, counts only in states 2, 5 and 7, and is cleared on every state entry.
- tx_comm_reset and tx_comm_wake are never both high.
- platform_ready=0 in any state other than IDLE: return to IDLE and set platform_error=1. platform_error stays set until reset.
- Simultaneous events: the platform_ready check has top priority, then the timeout, then the state's success condition.
- Unused codes 10-15: return to IDLE on the next clock.

Decomposition:
- Shared SATA package: PRIM_ALIGN=32'h7B4A4ABC, DATA_D10_2=32'h4A4A4A4A, OOB state codes.
- One sub-module: oob_timeout_counter (clear/enable/expired, TIMEOUT_CYCLES parameter). Everything else lives in one FSM.

Test Plan:
- Reset mid-handshake (rst=0 while in state 7) -> outputs immediately: linkup=0, tx_set_elec_idle=1, lax_state=0.
- Normal bring-up: platform_ready=1, then tx_oob_complete, comm_init_detect pulse, tx_oob_complete, comm_wake_detect pulse, ALIGN rx, 3 SYNC dwords (32'hB5B5957C, rx_is_k=1) -> lax_state walks 0-9 and linkup=1 one cycle after the 3rd SYNC.
- No COMINIT: remain in state 2 for TIMEOUT_CYCLES -> state 1 re-entered and tx_comm_reset=1 again.
- SEND_D10_2 check -> tx_dout=32'h4A4A4A4A, tx_is_k=0. ALIGN with rx_byte_is_aligned=0 is ignored; times out to state 1.
- In READY, assert phy_error for 1 cycle -> linkup=0, lax_state=0 next cycle.
- Drop platform_ready in state 5 -> platform_error=1 (sticky), state 0.

Source files
------------

// File: rtl/sata_oob_controller_pkg.sv
// Shared SATA OOB definitions: primitive dwords and the sequencer state codes.
// The state codes double as the debug encoding seen on the logic analyser port.
package sata_oob_controller_pkg;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] DATA_D10_2 = 32'h4A4A4A4A;

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_SEND_RESET    = 4'd1,
        ST_WAIT_INIT     = 4'd2,
        ST_WAIT_INIT_END = 4'd3,
        ST_SEND_WAKE     = 4'd4,
        ST_WAIT_WAKE     = 4'd5,
        ST_WAIT_WAKE_END = 4'd6,
        ST_SEND_D10_2    = 4'd7,
        ST_SEND_ALIGN    = 4'd8,
        ST_READY         = 4'd9
    } oob_state_t;

    // States that wait on the device and therefore run the response timer.
    function automatic logic is_timed_state(input oob_state_t s);
        return (s == ST_WAIT_INIT) || (s == ST_WAIT_WAKE) || (s == ST_SEND_D10_2);
    endfunction

endpackage

// File: rtl/oob_timeout_counter.sv
// 20-bit response timer; expired flags the last cycle of a TIMEOUT_CYCLES window.
// Clearing while disabled guarantees a zero count on entry to any timed state.
module oob_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 66000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [19:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 20'd1;
        end
    end

    assign o_expired = i_enable && (r_count == 20'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sata_oob_controller.sv
// Host-side SATA OOB sequencer: COMRESET/COMWAKE exchange, D10.2/ALIGN speed
// negotiation, then linkup once non-ALIGN primitives arrive.
module sata_oob_controller
    import sata_oob_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 66000,
    parameter int SYNC_COUNT     = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_phy_error,
    input  logic        i_platform_ready,
    output logic        o_platform_error,
    output logic        o_linkup,
    output logic [31:0] o_tx_dout,
    output logic        o_tx_is_k,
    output logic        o_tx_comm_reset,
    output logic        o_tx_comm_wake,
    output logic        o_tx_set_elec_idle,
    input  logic        i_tx_oob_complete,
    input  logic [31:0] i_rx_din,
    input  logic [3:0]  i_rx_is_k,
    input  logic        i_comm_init_detect,
    input  logic        i_comm_wake_detect,
    input  logic        i_rx_is_elec_idle,
    input  logic        i_rx_byte_is_aligned,
    output logic [3:0]  o_lax_state
);

    localparam int SYNC_W = $clog2(SYNC_COUNT + 1);

    oob_state_t        r_state;
    oob_state_t        w_next;
    logic [SYNC_W-1:0] r_sync;
    logic              r_platform_error;
    logic              r_linkup;
    logic [31:0]       r_tx_dout;
    logic              r_tx_is_k;
    logic              r_tx_comm_reset;
    logic              r_tx_comm_wake;
    logic              r_tx_set_elec_idle;
    logic              w_timer_enable;
    logic              w_expired;
    logic              w_platform_lost;
    logic              w_align_seen;
    logic              w_sync_hit;
    logic              w_unused_rx_k;

    assign w_unused_rx_k   = ^i_rx_is_k[3:1];
    assign w_timer_enable  = is_timed_state(r_state);
    assign w_platform_lost = (r_state != ST_IDLE) && !i_platform_ready;
    assign w_align_seen    = (i_rx_din == PRIM_ALIGN) && i_rx_is_k[0] && i_rx_byte_is_aligned;
    assign w_sync_hit      = i_rx_is_k[0] && (i_rx_din != PRIM_ALIGN) && !i_phy_error;

    oob_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (!w_timer_enable),
        .i_enable  (w_timer_enable),
        .o_expired (w_expired)
    );

    // Priority: platform loss, then timeout, then the state's own success condition.
    always_comb begin
        w_next = r_state;
        if (w_platform_lost) begin
            w_next = ST_IDLE;
        end else if (w_expired) begin
            w_next = ST_SEND_RESET;
        end else begin
            case (r_state)
                ST_IDLE:          if (i_platform_ready)    w_next = ST_SEND_RESET;
                ST_SEND_RESET:    if (i_tx_oob_complete)   w_next = ST_WAIT_INIT;
                ST_WAIT_INIT:     if (i_comm_init_detect)  w_next = ST_WAIT_INIT_END;
                ST_WAIT_INIT_END: if (!i_comm_init_detect) w_next = ST_SEND_WAKE;
                ST_SEND_WAKE:     if (i_tx_oob_complete)   w_next = ST_WAIT_WAKE;
                ST_WAIT_WAKE:     if (i_comm_wake_detect)  w_next = ST_WAIT_WAKE_END;
                ST_WAIT_WAKE_END: if (!i_comm_wake_detect) w_next = ST_SEND_D10_2;
                ST_SEND_D10_2:    if (w_align_seen)        w_next = ST_SEND_ALIGN;
                ST_SEND_ALIGN: begin
                    if (w_sync_hit && (r_sync == SYNC_W'(SYNC_COUNT - 1))) w_next = ST_READY;
                end
                ST_READY:         if (i_phy_error || i_rx_is_elec_idle) w_next = ST_IDLE;
                default:          w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change together with lax_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state            <= ST_IDLE;
            r_sync             <= '0;
            r_platform_error   <= 1'b0;
            r_linkup           <= 1'b0;
            r_tx_dout          <= '0;
            r_tx_is_k          <= 1'b0;
            r_tx_comm_reset    <= 1'b0;
            r_tx_comm_wake     <= 1'b0;
            r_tx_set_elec_idle <= 1'b1;
        end else begin
            r_state          <= w_next;
            r_platform_error <= r_platform_error | w_platform_lost;
            if ((r_state == ST_SEND_ALIGN) && (w_next == ST_SEND_ALIGN) && w_sync_hit) begin
                r_sync <= r_sync + SYNC_W'(1);
            end else begin
                r_sync <= '0;
            end
            r_linkup        <= (w_next == ST_READY);
            r_tx_comm_reset <= (w_next == ST_SEND_RESET);
            r_tx_comm_wake  <= (w_next == ST_SEND_WAKE);
            case (w_next)
                ST_SEND_D10_2: begin
                    r_tx_dout          <= DATA_D10_2;
                    r_tx_is_k          <= 1'b0;
                    r_tx_set_elec_idle <= 1'b0;
                end
                ST_SEND_ALIGN, ST_READY: begin
                    r_tx_dout          <= PRIM_ALIGN;
                    r_tx_is_k          <= 1'b1;
                    r_tx_set_elec_idle <= 1'b0;
                end
                default: begin
                    r_tx_dout          <= '0;
                    r_tx_is_k          <= 1'b0;
                    r_tx_set_elec_idle <= 1'b1;
                end
            endcase
        end
    end

    assign o_lax_state        = r_state;
    assign o_platform_error   = r_platform_error;
    assign o_linkup           = r_linkup;
    assign o_tx_dout          = r_tx_dout;
    assign o_tx_is_k          = r_tx_is_k;
    assign o_tx_comm_reset    = r_tx_comm_reset;
    assign o_tx_comm_wake     = r_tx_comm_wake;
    assign o_tx_set_elec_idle = r_tx_set_elec_idle;

endmodule

// File: tb/tb_sata_oob_controller.sv
// Scoreboard bench for the SATA OOB sequencer: the driver pushes the expected
// output snapshot after each clock, the monitor pops and compares on the falling edge.
module tb_sata_oob_controller;

    localparam int TIMEOUT = 40;
    localparam int SYNCS   = 3;
    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [31:0] D10_DW   = 32'h4A4A4A4A;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rstN;
    logic        phyError;
    logic        platformReady;
    logic        platformError;
    logic        linkup;
    logic [31:0] txDout;
    logic        txIsK;
    logic        txCommReset;
    logic        txCommWake;
    logic        txElecIdle;
    logic        txOobComplete;
    logic [31:0] rxDin;
    logic [3:0]  rxIsK;
    logic        commInit;
    logic        commWake;
    logic        rxElecIdle;
    logic        rxAligned;
    logic [3:0]  laxState;

    typedef struct {
        string       name;
        logic [41:0] exp;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;

    // Free-running 100 MHz-style clock; only relative timing matters here.
    always #5 clk = ~clk;

    sata_oob_controller #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_COUNT    (SYNCS)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rstN),
        .i_phy_error         (phyError),
        .i_platform_ready    (platformReady),
        .o_platform_error    (platformError),
        .o_linkup            (linkup),
        .o_tx_dout           (txDout),
        .o_tx_is_k           (txIsK),
        .o_tx_comm_reset     (txCommReset),
        .o_tx_comm_wake      (txCommWake),
        .o_tx_set_elec_idle  (txElecIdle),
        .i_tx_oob_complete   (txOobComplete),
        .i_rx_din            (rxDin),
        .i_rx_is_k           (rxIsK),
        .i_comm_init_detect  (commInit),
        .i_comm_wake_detect  (commWake),
        .i_rx_is_elec_idle   (rxElecIdle),
        .i_rx_byte_is_aligned(rxAligned),
        .o_lax_state         (laxState)
    );

    // Builds the full expected output word for a given state code and sticky error.
    function automatic logic [41:0] expectedOutputs(input int lax, input bit perr);
        logic [31:0] dout;
        logic        isK;
        logic        eIdle;
        dout  = 32'h0;
        isK   = 1'b0;
        eIdle = 1'b1;
        if (lax == 7) begin
            dout  = D10_DW;
            eIdle = 1'b0;
        end else if (lax == 8 || lax == 9) begin
            dout  = ALIGN_DW;
            isK   = 1'b1;
            eIdle = 1'b0;
        end
        return {(lax == 9), dout, isK, (lax == 1), (lax == 4), eIdle, perr, 4'(lax)};
    endfunction

    // Compares one scoreboard entry against the live DUT outputs.
    task automatic checkOutput(input expT e);
        logic [41:0] act;
        act = {linkup, txDout, txIsK, txCommReset, txCommWake, txElecIdle, platformError, laxState};
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("[TB] FAIL %s: got lax=%0d out=%h, expected lax=%0d out=%h",
                     e.name, act[3:0], act, e.exp[3:0], e.exp);
        end
    endtask

    // Monitor: drains every pending expectation on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    // One clock of stimulus: inputs already set, expect this state after the edge.
    task automatic applyStimulus(input string name, input int expLax, input bit expPerr);
        @(posedge clk);
        sb.push_back('{name, expectedOutputs(expLax, expPerr)});
        @(negedge clk);
    endtask

    // Walks from SEND_RESET through to SEND_D10_2 with single-cycle device responses.
    task automatic walkToD10(input bit perr);
        txOobComplete = 1'b1; applyStimulus("toWaitInit", 2, perr);
        txOobComplete = 1'b0; commInit = 1'b1; applyStimulus("toInitEnd", 3, perr);
        commInit = 1'b0;      applyStimulus("toSendWake", 4, perr);
        txOobComplete = 1'b1; applyStimulus("toWaitWake", 5, perr);
        txOobComplete = 1'b0; commWake = 1'b1; applyStimulus("toWakeEnd", 6, perr);
        commWake = 1'b0;      applyStimulus("toD10", 7, perr);
    endtask

    // Main directed sequence.
    initial begin
        rstN = 1'b0; phyError = 1'b0; platformReady = 1'b0; txOobComplete = 1'b0;
        rxDin = 32'h0; rxIsK = 4'h0; commInit = 1'b0; commWake = 1'b0;
        rxElecIdle = 1'b0; rxAligned = 1'b0;
        #1;
        sb.push_back('{"resetState", expectedOutputs(0, 1'b0)});
        @(negedge clk);
        rstN = 1'b1;

        // Normal bring-up, including a SYNC run broken by an ALIGN.
        platformReady = 1'b1; applyStimulus("idleToReset", 1, 1'b0);
        applyStimulus("holdReset", 1, 1'b0);
        txOobComplete = 1'b1; applyStimulus("resetDone", 2, 1'b0);
        txOobComplete = 1'b0; applyStimulus("waitInit", 2, 1'b0);
        commInit = 1'b1; applyStimulus("initSeen", 3, 1'b0);
        applyStimulus("initHeld", 3, 1'b0);
        commInit = 1'b0; applyStimulus("initEnd", 4, 1'b0);
        applyStimulus("holdWake", 4, 1'b0);
        txOobComplete = 1'b1; applyStimulus("wakeDone", 5, 1'b0);
        txOobComplete = 1'b0; commWake = 1'b1; applyStimulus("wakeSeen", 6, 1'b0);
        commWake = 1'b0; applyStimulus("wakeEnd", 7, 1'b0);
        rxDin = ALIGN_DW; rxIsK = 4'h1; rxAligned = 1'b1; applyStimulus("alignRx", 8, 1'b0);
        rxDin = SYNC_DW;  applyStimulus("sync1", 8, 1'b0);
        rxDin = ALIGN_DW; applyStimulus("syncBroken", 8, 1'b0);
        rxDin = SYNC_DW;  applyStimulus("syncA", 8, 1'b0);
        applyStimulus("syncB", 8, 1'b0);
        applyStimulus("syncC", 9, 1'b0);
        applyStimulus("readyHold", 9, 1'b0);
        phyError = 1'b1; applyStimulus("phyErrDrop", 0, 1'b0);
        phyError = 1'b0; rxDin = 32'h0; rxIsK = 4'h0; rxAligned = 1'b0;
        applyStimulus("restart", 1, 1'b0);

        // No COMINIT: WAIT_INIT lasts exactly TIMEOUT cycles.
        txOobComplete = 1'b1; applyStimulus("toWaitInitTo", 2, 1'b0);
        txOobComplete = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) applyStimulus("waitInitTimer", 2, 1'b0);
        applyStimulus("initTimeout", 1, 1'b0);

        // Unaligned ALIGN ignored in SEND_D10_2; timeout beats a late valid ALIGN.
        walkToD10(1'b0);
        rxDin = ALIGN_DW; rxIsK = 4'h1; rxAligned = 1'b0;
        for (int i = 1; i < TIMEOUT; i++) applyStimulus("d10Unaligned", 7, 1'b0);
        rxAligned = 1'b1; applyStimulus("d10TimeoutWins", 1, 1'b0);
        rxDin = 32'h0; rxIsK = 4'h0; rxAligned = 1'b0;

        // Platform lost in WAIT_WAKE, simultaneous with COMWAKE: error wins and sticks.
        txOobComplete = 1'b1; applyStimulus("pl2", 2, 1'b0);
        txOobComplete = 1'b0; commInit = 1'b1; applyStimulus("pl3", 3, 1'b0);
        commInit = 1'b0;      applyStimulus("pl4", 4, 1'b0);
        txOobComplete = 1'b1; applyStimulus("pl5", 5, 1'b0);
        txOobComplete = 1'b0; platformReady = 1'b0; commWake = 1'b1;
        applyStimulus("platformLost", 0, 1'b1);
        commWake = 1'b0; applyStimulus("idleNoPlatform", 0, 1'b1);
        platformReady = 1'b1; applyStimulus("errorSticky", 1, 1'b1);
        applyStimulus("errorStillSet", 1, 1'b1);

        // Asynchronous reset while in SEND_D10_2.
        walkToD10(1'b1);
        @(posedge clk);
        #1 rstN = 1'b0;
        sb.push_back('{"asyncResetMid", expectedOutputs(0, 1'b0)});
        @(negedge clk);
        applyStimulus("resetHeld", 0, 1'b0);
        rstN = 1'b1; platformReady = 1'b0;
        applyStimulus("idleAfterReset", 0, 1'b0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
